// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, diff = (a - b) mod 2^WIDTH, LSB first.
// Latency WIDTH clocks from the edge accepting start to the done pulse; one op per WIDTH clocks.
// start is ignored while busy; diff/bout hold the last result until the next completion.
//
// Ports:
//   clk, rst      : single clock, synchronous active-high reset
//   start, a, b   : request and operands, sampled together on the accepting edge
//   diff, bout    : registered result and borrow out (bout = a < b)
//   busy, done    : operation in progress / one-cycle completion pulse
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sa, sa_n;
  logic [WIDTH-1:0] sb, sb_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic             br, br_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] diff_n;
  logic             bout_n;
  logic             done_n;
  logic             d;

  // State and datapath registers; reset wins over any coincident start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      sa    <= sa_n;
      sb    <= sb_n;
      sr    <= sr_n;
      br    <= br_n;
      cnt   <= cnt_n;
      diff  <= diff_n;
      bout  <= bout_n;
      done  <= done_n;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_n = state;
    sa_n    = sa;
    sb_n    = sb;
    sr_n    = sr;
    br_n    = br;
    cnt_n   = cnt;
    diff_n  = diff;
    bout_n  = bout;
    done_n  = 1'b0;
    d       = sa[0] ^ sb[0] ^ br;

    unique case (state)
      IDLE: begin
        if (start) begin
          sa_n    = a;
          sb_n    = b;
          sr_n    = '0;
          br_n    = 1'b0;
          cnt_n   = '0;
          state_n = RUN;
        end
      end
      RUN: begin
        // Full-subtractor borrow: borrow when a=0,b=1, or propagate when a==b.
        br_n  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
        sr_n  = {d, sr[WIDTH-1:1]};
        sa_n  = sa >> 1;
        sb_n  = sb >> 1;
        cnt_n = cnt + 1'b1;
        if (cnt == LAST) begin
          // Publish the shifted value that already includes this bit.
          diff_n  = sr_n;
          bout_n  = br_n;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] diff;
  logic         bout;
  logic         busy;
  logic         done;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .diff (diff),
    .bout (bout),
    .busy (busy),
    .done (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int unsigned diff;
    int unsigned bout;
    int          due;
  } exp_t;

  exp_t exp_q[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: transaction-level view of the handshake timing.
  bit          m_busy = 0;
  bit          m_done = 0;
  int          m_end  = 0;
  int unsigned m_diff = 0;
  int unsigned m_bout = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, expv);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    cyc++;
    m_done = 0;
    if (rst) begin
      m_busy = 0;
      m_diff = 0;
      m_bout = 0;
      exp_q.delete();
    end else if (m_busy) begin
      if (cyc == m_end) begin
        m_busy = 0;
        m_done = 1;
        m_diff = exp_q[0].diff;
        m_bout = exp_q[0].bout;
      end
    end else if (start) begin
      int ai, bi;
      ai     = int'(a);
      bi     = int'(b);
      e.diff = (ai - bi + (1 << W)) % (1 << W);
      e.bout = (ai < bi) ? 1 : 0;
      e.due  = cyc + W;
      exp_q.push_back(e);
      m_busy = 1;
      m_end  = cyc + W;
    end
  end

  // Monitor: scoreboard pop on every done, plus handshake and hold checks each cycle.
  always @(negedge clk) begin
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    if (done) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done at cycle %0d: got done=1 expected no pending op", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("diff_on_done", diff, e.diff);
        chk("bout_on_done", bout, e.bout);
        chk("latency", cyc, e.due);
      end
    end
    chk("diff_hold", diff, m_diff);
    chk("bout_hold", bout, m_bout);
  end

  // Wait at a negedge until the model is idle, then present one start pulse.
  task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv);
    int n = 0;
    @(negedge clk);
    while (m_busy && n < 4 * W) begin
      @(negedge clk);
      n++;
    end
    if (m_busy) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout at cycle %0d: got busy=1 expected idle", cyc);
    end
    start = 1'b1;
    a     = av;
    b     = bv;
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (m_busy && n < 4 * W) begin
      @(negedge clk);
      n++;
    end
    if (m_busy) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout at cycle %0d: got busy=1 expected idle", cyc);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    a     = W'($urandom);
    b     = W'($urandom);
    repeat (2) begin
      @(negedge clk);
      chk("rst_diff", diff, 0);
      chk("rst_bout", bout, 0);
      chk("rst_busy", busy, 0);
      a = W'($urandom);
      b = W'($urandom);
    end
    rst   = 1'b0;
    start = 1'b0;

    // Directed cases.
    op(4'b0111, 4'b0010);
    op(4'b0001, 4'b0110);
    op(4'b0000, 4'b0001);
    op(4'b1111, 4'b1111);

    // Start during busy is ignored, then start in the done cycle.
    op(4'b1000, 4'b0011);
    @(negedge clk);
    start = 1'b1; a = 4'b0000; b = 4'b1111;
    @(negedge clk);
    start = 1'b0;
    begin
      int n = 0;
      while (!m_done && n < 4 * W) begin
        @(negedge clk);
        n++;
      end
      chk("done_cycle_reached", m_done, 1);
    end
    start = 1'b1; a = 4'b0011; b = 4'b0111;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    @(negedge clk);
    chk("bb_diff", diff, 4'b1100);
    chk("bb_bout", bout, 1);

    // Abort with reset after two RUN edges.
    op(4'b0111, 4'b0010);
    wait_idle();
    @(negedge clk);
    chk("hold_before_abort", diff, 4'b0101);
    start = 1'b1; a = 4'b1001; b = 4'b0001;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_diff", diff, 0);
    chk("abort_bout", bout, 0);
    op(4'b1001, 4'b0001);
    wait_idle();

    // Exhaustive sweep, back to back.
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        op(W'(i), W'(j));
    wait_idle();

    // Randomized ops with random gaps.
    for (int k = 0; k < 100; k++) begin
      op(W'($urandom), W'($urandom));
      repeat ($urandom_range(0, 6)) begin
        @(negedge clk);
        start = ($urandom_range(0, 3) == 0);
        a = W'($urandom);
        b = W'($urandom);
      end
      start = 1'b0;
    end

    // start held high with operands changing every cycle.
    @(negedge clk);
    start = 1'b1;
    repeat (80) begin
      a = W'($urandom);
      b = W'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
